// File: rtl/cmult_pipe.sv
// cmult_pipe: pipelined, handshaked fixed-point complex multiplier.
//   S = A*B, or S = A*conj(B) when in_conj is set with the operands.
//   Operands and results are signed Q(DATA_W-FRAC_W).FRAC_W; results are
//   rounded half toward +inf and saturated back to DATA_W bits.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               operand handshake (in_ready = ~stall)
//   in_conj, in_tag                 per-transaction conj flag and opaque tag
//   a_real, a_img, b_real, b_img    signed operands
//   out_valid/out_ready             result handshake
//   s_real, s_img, out_tag, out_sat result, its tag and clamp flag
// Pipeline ranks: S1 operands, S2 products, S3 sums, S4 rounded/shifted,
// then the output register, which clamps. Results appear 4 edges after
// the accepting edge. A stalled output freezes every rank.
module cmult_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FRAC_W = DATA_W - 2,
   parameter int unsigned TAG_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_conj,
   input  logic [TAG_W-1:0]         in_tag,
   input  logic signed [DATA_W-1:0] a_real,
   input  logic signed [DATA_W-1:0] a_img,
   input  logic signed [DATA_W-1:0] b_real,
   input  logic signed [DATA_W-1:0] b_img,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] s_real,
   output logic signed [DATA_W-1:0] s_img,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_sat
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned SUM_W  = 2 * DATA_W + 1;
   localparam int unsigned HI_W   = SUM_W - DATA_W + 1;
   localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) << (FRAC_W - 1);

   // S1: registered operands
   logic                     s1_v, s1_conj;
   logic [TAG_W-1:0]         s1_tag;
   logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;
   // S2: partial products
   logic                     s2_v, s2_conj;
   logic [TAG_W-1:0]         s2_tag;
   logic signed [PROD_W-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
   // S3: full-precision sums
   logic                     s3_v;
   logic [TAG_W-1:0]         s3_tag;
   logic signed [SUM_W-1:0]  s3_re, s3_im;
   // S4: rounded and shifted, not yet clamped
   logic                     s4_v;
   logic [TAG_W-1:0]         s4_tag;
   logic signed [SUM_W-1:0]  s4_re, s4_im;

   logic                     stall_c, en_c;
   logic signed [SUM_W-1:0]  re_c, im_c, re_rnd_c, im_rnd_c;
   logic [DATA_W-1:0]        re_sat_c, im_sat_c;
   logic                     re_clamp_c, im_clamp_c;

   // Returns {clamped, value}: clamp when the upper bits are not a pure sign extension.
   function automatic logic [DATA_W:0] sat_fn(input logic signed [SUM_W-1:0] x);
      logic [HI_W-1:0] hi;
      hi = x[SUM_W-1:DATA_W-1];
      if ((&hi) || (~|hi))
         sat_fn = {1'b0, x[DATA_W-1:0]};
      else if (x[SUM_W-1])
         sat_fn = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
      else
         sat_fn = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
   endfunction

   // Backpressure: a held result freezes the whole pipe
   assign stall_c  = out_valid & ~out_ready;
   assign en_c     = ~stall_c;
   assign in_ready = en_c;

   // Sum, round and clamp datapath between ranks
   always_comb begin
      re_c = '0;
      im_c = '0;
      if (s2_conj) begin
         re_c = SUM_W'(s2_rr) + SUM_W'(s2_ii);
         im_c = SUM_W'(s2_ir) - SUM_W'(s2_ri);
      end else begin
         re_c = SUM_W'(s2_rr) - SUM_W'(s2_ii);
         im_c = SUM_W'(s2_ri) + SUM_W'(s2_ir);
      end
      re_rnd_c = (s3_re + HALF) >>> FRAC_W;
      im_rnd_c = (s3_im + HALF) >>> FRAC_W;
      {re_clamp_c, re_sat_c} = sat_fn(s4_re);
      {im_clamp_c, im_sat_c} = sat_fn(s4_im);
   end

   // Pipeline ranks; data only loads behind a valid so bubbles keep outputs quiet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0; s1_conj <= 1'b0; s1_tag <= '0;
         s1_ar <= '0; s1_ai <= '0; s1_br <= '0; s1_bi <= '0;
         s2_v <= 1'b0; s2_conj <= 1'b0; s2_tag <= '0;
         s2_rr <= '0; s2_ii <= '0; s2_ri <= '0; s2_ir <= '0;
         s3_v <= 1'b0; s3_tag <= '0; s3_re <= '0; s3_im <= '0;
         s4_v <= 1'b0; s4_tag <= '0; s4_re <= '0; s4_im <= '0;
         out_valid <= 1'b0; out_tag <= '0; out_sat <= 1'b0;
         s_real <= '0; s_img <= '0;
      end else if (en_c) begin
         s1_v <= in_valid;
         if (in_valid) begin
            s1_conj <= in_conj;
            s1_tag  <= in_tag;
            s1_ar   <= a_real;
            s1_ai   <= a_img;
            s1_br   <= b_real;
            s1_bi   <= b_img;
         end
         s2_v <= s1_v;
         if (s1_v) begin
            s2_conj <= s1_conj;
            s2_tag  <= s1_tag;
            s2_rr   <= PROD_W'(s1_ar) * PROD_W'(s1_br);
            s2_ii   <= PROD_W'(s1_ai) * PROD_W'(s1_bi);
            s2_ri   <= PROD_W'(s1_ar) * PROD_W'(s1_bi);
            s2_ir   <= PROD_W'(s1_ai) * PROD_W'(s1_br);
         end
         s3_v <= s2_v;
         if (s2_v) begin
            s3_tag <= s2_tag;
            s3_re  <= re_c;
            s3_im  <= im_c;
         end
         s4_v <= s3_v;
         if (s3_v) begin
            s4_tag <= s3_tag;
            s4_re  <= re_rnd_c;
            s4_im  <= im_rnd_c;
         end
         out_valid <= s4_v;
         if (s4_v) begin
            out_tag <= s4_tag;
            s_real  <= re_sat_c;
            s_img   <= im_sat_c;
            out_sat <= re_clamp_c | im_clamp_c;
         end
      end
   end

endmodule

// File: tb/tb_cmult_pipe.sv
// Self-checking bench for cmult_pipe (DATA_W=16, FRAC_W=14, TAG_W=8).
// Expected results come from plain integer arithmetic on the operands;
// a queue of expected results tracks ordering, tags and latency.
module tb_cmult_pipe;

   localparam int unsigned DW = 16;
   localparam int unsigned FW = 14;
   localparam int unsigned TW = 8;

   logic                 clk, rst_n;
   logic                 in_valid, in_ready, in_conj;
   logic [TW-1:0]        in_tag, out_tag;
   logic signed [DW-1:0] a_real, a_img, b_real, b_img, s_real, s_img;
   logic                 out_valid, out_ready, out_sat;

   typedef struct {
      logic signed [DW-1:0] r;
      logic signed [DW-1:0] i;
      logic [TW-1:0]        tag;
      logic                 sat;
      int                   acc;
   } exp_t;

   exp_t              q[$];
   int                total = 0;
   int                bad = 0;
   int                cyc = 0;
   int                sent;
   bit                lat_chk;
   bit                prev_stall;
   bit                acc_b;
   logic [2*DW+TW:0]  held;

   cmult_pipe #(.DATA_W(DW), .FRAC_W(FW), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_conj(in_conj), .in_tag(in_tag),
      .a_real(a_real), .a_img(a_img), .b_real(b_real), .b_img(b_img),
      .out_valid(out_valid), .out_ready(out_ready),
      .s_real(s_real), .s_img(s_img), .out_tag(out_tag), .out_sat(out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Round half toward +inf, then clamp into DW bits
   function automatic longint round_val(input longint x);
      return (x + (longint'(1) <<< (FW - 1))) >>> FW;
   endfunction

   function automatic exp_t model(input logic signed [DW-1:0] ar, ai, br, bi,
                                  input logic cj, input logic [TW-1:0] tg);
      exp_t   e;
      longint rr, ii, ri, ir, re, im, lo, hi;
      bit     cr, ci;
      rr = longint'(ar) * longint'(br);
      ii = longint'(ai) * longint'(bi);
      ri = longint'(ar) * longint'(bi);
      ir = longint'(ai) * longint'(br);
      re = round_val(cj ? rr + ii : rr - ii);
      im = round_val(cj ? ir - ri : ri + ir);
      lo = -(longint'(1) <<< (DW - 1));
      hi = (longint'(1) <<< (DW - 1)) - 1;
      cr = (re < lo) || (re > hi);
      ci = (im < lo) || (im > hi);
      if (re < lo) re = lo;
      if (re > hi) re = hi;
      if (im < lo) im = lo;
      if (im > hi) im = hi;
      e.r   = DW'(re);
      e.i   = DW'(im);
      e.tag = tg;
      e.sat = cr | ci;
      e.acc = 0;
      return e;
   endfunction

   // One clock: check handshake/output state, record transfers, advance one edge
   task automatic tick(output bit acc);
      exp_t e;
      #1;
      acc = 1'b0;
      total++;
      assert (in_ready === !(out_valid && !out_ready)) else begin
         bad++;
         $error("FAIL in_ready: got %b exp %b", in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
         total++;
         assert ({out_valid, s_real, s_img, out_tag, out_sat} === {1'b1, held}) else begin
            bad++;
            $error("FAIL stall_hold: got v=%b re=%0d im=%0d tag=%0d exp held=%h",
                   out_valid, s_real, s_img, out_tag, held);
         end
      end
      if (q.size() == 0) begin
         total++;
         assert (out_valid === 1'b0) else begin
            bad++;
            $error("FAIL spurious_out: got out_valid=%b exp 0 (re=%0d tag=%0d)",
                   out_valid, s_real, out_tag);
         end
      end else if (out_valid === 1'b1 && out_ready) begin
         e = q.pop_front();
         total++;
         assert ({s_real, s_img, out_tag, out_sat} === {e.r, e.i, e.tag, e.sat}) else begin
            bad++;
            $error("FAIL result: got re=%0d im=%0d tag=%0d sat=%b exp re=%0d im=%0d tag=%0d sat=%b",
                   s_real, s_img, out_tag, out_sat, e.r, e.i, e.tag, e.sat);
         end
         if (lat_chk) begin
            total++;
            assert (cyc - 1 - e.acc == 4) else begin
               bad++;
               $error("FAIL latency tag=%0d: got %0d exp 4", e.tag, cyc - 1 - e.acc);
            end
         end
      end
      if (in_valid && in_ready) begin
         e = model(a_real, a_img, b_real, b_img, in_conj, in_tag);
         e.acc = cyc;
         q.push_back(e);
         acc = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      held = {s_real, s_img, out_tag, out_sat};
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic signed [DW-1:0] ar, ai, br, bi,
                       input logic cj, input logic [TW-1:0] tg);
      bit acc;
      a_real = ar; a_img = ai; b_real = br; b_img = bi;
      in_conj = cj; in_tag = tg; in_valid = 1'b1;
      tick(acc);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) tick(acc);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_conj = 1'b0; in_tag = '0;
      a_real = '0; a_img = '0; b_real = '0; b_img = '0; out_ready = 1'b1;
      prev_stall = 1'b0; lat_chk = 1'b1; held = '0;

      // Reset state
      #2;
      total++;
      assert ({out_valid, s_real, s_img, out_tag, out_sat, in_ready} === {1'b0, {(2*DW+TW+1){1'b0}}, 1'b1}) else begin
         bad++;
         $error("FAIL reset_state: got v=%b re=%0d im=%0d tag=%0d sat=%b rdy=%b exp zeros rdy=1",
                out_valid, s_real, s_img, out_tag, out_sat, in_ready);
      end
      #1 rst_n = 1'b1;

      // Directed: 1 * j, then conjugate, on the first edge after reset
      send(16'sd16384, 16'sd0, 16'sd0, 16'sd16384, 1'b0, 8'd1);
      idle(6);
      send(16'sd16384, 16'sd0, 16'sd0, 16'sd16384, 1'b1, 8'd2);
      send(16'sd11585, 16'sd11585, 16'sd11585, 16'sd11585, 1'b1, 8'd3);
      // Saturation and large-magnitude cases
      send(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 1'b0, 8'd4);
      send(16'sh8000, 16'sd0, 16'sd32767, 16'sd0, 1'b0, 8'd5);
      send(16'sd32767, 16'sd32767, 16'sh8000, 16'sd32767, 1'b1, 8'd6);
      // Rounding boundaries
      send(16'sd1, 16'sd0, 16'sd8192, 16'sd0, 1'b0, 8'd7);
      send(-16'sd1, 16'sd0, 16'sd8192, 16'sd0, 1'b0, 8'd8);
      send(-16'sd1, 16'sd0, 16'sd8191, 16'sd0, 1'b0, 8'd9);
      send(-16'sd1, 16'sd0, 16'sd8193, 16'sd0, 1'b0, 8'd10);
      idle(8);

      // Random stream under random backpressure, including a long full-pipe stall
      lat_chk = 1'b0;
      sent = 0;
      for (int c = 0; c < 600 && !(sent == 20 && q.size() == 0); c++) begin
         if (!in_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
            a_real = DW'($urandom); a_img = DW'($urandom);
            b_real = DW'($urandom); b_img = DW'($urandom);
            in_conj = 1'($urandom); in_tag = TW'($urandom);
            in_valid = 1'b1;
         end
         out_ready = (c >= 15 && c < 25) ? 1'b0 : ($urandom_range(0, 2) != 0);
         tick(acc_b);
         if (acc_b) begin
            sent++;
            in_valid = 1'b0;
         end
      end
      total++;
      assert (sent == 20 && q.size() == 0) else begin
         bad++;
         $error("FAIL stream_drain: got sent=%0d pending=%0d exp sent=20 pending=0", sent, q.size());
      end
      out_ready = 1'b1;
      idle(2);

      // Reset with three transactions in flight
      lat_chk = 1'b1;
      send(16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000, 1'b0, 8'd50);
      send(16'sd5000, -16'sd6000, 16'sd7000, 16'sd800, 1'b1, 8'd51);
      send(-16'sd900, 16'sd100, 16'sd200, -16'sd300, 1'b0, 8'd52);
      #2 rst_n = 1'b0;
      #1;
      total++;
      assert ({out_valid, s_real, s_img, out_tag, out_sat, in_ready} === {1'b0, {(2*DW+TW+1){1'b0}}, 1'b1}) else begin
         bad++;
         $error("FAIL midstream_reset: got v=%b re=%0d im=%0d tag=%0d sat=%b rdy=%b exp zeros rdy=1",
                out_valid, s_real, s_img, out_tag, out_sat, in_ready);
      end
      q.delete();
      prev_stall = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      idle(8);
      send(16'sd12345, -16'sd2345, -16'sd4321, 16'sd16000, 1'b1, 8'd99);
      idle(7);
      total++;
      assert (q.size() == 0) else begin
         bad++;
         $error("FAIL post_reset_drain: got pending=%0d exp 0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
